// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the off-chip memory port arbiter.
//   state_t        : arbiter FSM states (IDLE, BUSY, RESP)
//   DEF_ADDR_W     : default memory address width
//   DEF_LINE_W     : default cache-line width
//   PORT_I/PORT_D  : requester indices (instruction cache / data cache)
//   port_onehot()  : converts a requester index into a one-hot grant vector
// ---------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_LINE_W = 256;

    localparam int PORT_I = 0;
    localparam int PORT_D = 1;

    function automatic logic [1:0] port_onehot(input logic idx);
        logic [1:0] vec;
        vec = 2'b00;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Combinational two-way picker used by the memory port arbiter.
//   req        : request vector, bit PORT_I = icache, bit PORT_D = dcache
//   last_grant : index of the port that won the previous transaction
//   fixed_prio : 1 makes the dcache port win every tie
//   gnt        : one-hot winner, 00 when nobody requests
// ---------------------------------------------------------------------------
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       fixed_prio,
    output logic [1:0] gnt
);

    // A lone requester always wins. On a tie, either the dcache port wins
    // unconditionally, or the port that did not win last time gets its turn.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt[PORT_I] = 1'b1;
            2'b10:   gnt[PORT_D] = 1'b1;
            2'b11: begin
                if (fixed_prio) begin
                    gnt[PORT_D] = 1'b1;
                end else if (last_grant == 1'b1) begin
                    gnt[PORT_I] = 1'b1;
                end else begin
                    gnt[PORT_D] = 1'b1;
                end
            end
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares the single off-chip line-wide memory port between the instruction
// cache (port 0) and the data cache (port 1). One transaction at a time:
// the winner's request is latched into the mem_* registers and held for the
// whole transaction, and the memory ack plus read line are routed back to
// that requester one cycle later.
//
// Ports:
//   clk_i, rst_i                 : clock, synchronous active-high reset
//   pN_enable_i / pN_write_i     : request and direction from requester N
//   pN_addr_i / pN_data_i        : line address and write line from requester N
//   pN_ack_o / pN_data_o         : completion pulse and read line to requester N
//   mem_enable_o / mem_write_o   : request and direction to memory
//   mem_addr_o / mem_data_o      : address and write line to memory
//   mem_ack_i / mem_data_i       : completion pulse and read line from memory
//   grant_o                      : one-hot current owner, 00 when idle
//   timeout_o                    : sticky flag, a transaction stayed BUSY too long
// ---------------------------------------------------------------------------
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int LINE_W         = DEF_LINE_W,
    parameter int FIXED_PRIO     = 0,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              p0_enable_i,
    input  logic              p0_write_i,
    input  logic [ADDR_W-1:0] p0_addr_i,
    input  logic [LINE_W-1:0] p0_data_i,
    output logic              p0_ack_o,
    output logic [LINE_W-1:0] p0_data_o,

    input  logic              p1_enable_i,
    input  logic              p1_write_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [LINE_W-1:0] p1_data_i,
    output logic              p1_ack_o,
    output logic [LINE_W-1:0] p1_data_o,

    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic              mem_ack_i,
    input  logic [LINE_W-1:0] mem_data_i,

    output logic [1:0]        grant_o,
    output logic              timeout_o
);

    // The watchdog counter only needs to reach TIMEOUT_CYCLES; it stops
    // counting once the sticky flag is set, so it can never wrap.
    localparam int CNT_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    state_t           state;
    logic             last_grant;
    logic             owner;
    logic [CNT_W-1:0] wd_cnt;
    logic [1:0]       req;
    logic [1:0]       pick;

    assign req[PORT_I] = p0_enable_i;
    assign req[PORT_D] = p1_enable_i;

    rr_arb2 u_arb (
        .req        (req),
        .last_grant (last_grant),
        .fixed_prio (FIXED_PRIO != 0),
        .gnt        (pick)
    );

    // Arbiter FSM with every output registered. IDLE latches the winner's
    // request, BUSY holds the memory side steady until the memory acks (the
    // requester inputs are deliberately ignored there), and RESP is the
    // single cycle in which the owner sees its ack and read line. The read
    // line stays on the owner's data_o until that port is served again.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            owner        <= 1'b0;
            wd_cnt       <= '0;
            p0_ack_o     <= 1'b0;
            p0_data_o    <= '0;
            p1_ack_o     <= 1'b0;
            p1_data_o    <= '0;
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= '0;
            mem_data_o   <= '0;
            grant_o      <= 2'b00;
            timeout_o    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick != 2'b00) begin
                        owner        <= pick[PORT_D];
                        grant_o      <= pick;
                        mem_enable_o <= 1'b1;
                        wd_cnt       <= '0;
                        if (pick[PORT_D]) begin
                            mem_write_o <= p1_write_i;
                            mem_addr_o  <= p1_addr_i;
                            mem_data_o  <= p1_data_i;
                        end else begin
                            mem_write_o <= p0_write_i;
                            mem_addr_o  <= p0_addr_i;
                            mem_data_o  <= p0_data_i;
                        end
                        state <= BUSY;
                    end
                end

                BUSY: begin
                    // The watchdog only raises a flag; the transaction keeps
                    // waiting for the memory regardless.
                    if (TIMEOUT_CYCLES != 0 && !timeout_o) begin
                        wd_cnt <= wd_cnt + CNT_W'(1);
                        if (wd_cnt == CNT_W'(TO_LAST)) begin
                            timeout_o <= 1'b1;
                        end
                    end
                    if (mem_ack_i) begin
                        mem_enable_o <= 1'b0;
                        grant_o      <= 2'b00;
                        last_grant   <= owner;
                        if (owner) begin
                            p1_ack_o  <= 1'b1;
                            p1_data_o <= mem_data_i;
                        end else begin
                            p0_ack_o  <= 1'b1;
                            p0_data_o <= mem_data_i;
                        end
                        state <= RESP;
                    end
                end

                RESP: begin
                    p0_ack_o <= 1'b0;
                    p1_ack_o <= 1'b0;
                    state    <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // grant_o must always agree with the latched owner while BUSY; a
    // disagreement means the datapath and the FSM have drifted apart.
    always_ff @(posedge clk_i) begin
        if (!rst_i && state == BUSY) begin
            assert (grant_o == port_onehot(owner))
                else $error("grant_o does not match owner");
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter. Instance "dut" runs round-robin with a
// 16-cycle watchdog and its memory side is driven by hand; instance "dut_fp"
// runs fixed priority with a small automatic memory responder.
// Inputs are driven and outputs sampled just after the falling edge.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;

    logic clk = 1'b0;
    logic rst_i;

    always #5 clk = ~clk;

    logic              p0_enable, p0_write, p0_ack;
    logic [ADDR_W-1:0] p0_addr;
    logic [LINE_W-1:0] p0_data, p0_rdata;
    logic              p1_enable, p1_write, p1_ack;
    logic [ADDR_W-1:0] p1_addr;
    logic [LINE_W-1:0] p1_data, p1_rdata;
    logic              mem_enable, mem_write, mem_ack;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_data, mem_rdata;
    logic [1:0]        grant;
    logic              timeout;

    logic              fp_p0_enable, fp_p0_ack, fp_p1_enable, fp_p1_ack;
    logic [LINE_W-1:0] fp_p0_rdata, fp_p1_rdata, fp_mem_data;
    logic              fp_mem_enable, fp_mem_write, fp_mem_ack;
    logic [ADDR_W-1:0] fp_mem_addr;
    logic [1:0]        fp_grant;
    logic              fp_timeout;
    int                fp_cnt = 0;
    logic              fp_p0_seen = 1'b0;

    int n_compared   = 0;
    int n_mismatched = 0;

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .LINE_W(LINE_W), .FIXED_PRIO(0), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .p0_enable_i(p0_enable), .p0_write_i(p0_write), .p0_addr_i(p0_addr),
        .p0_data_i(p0_data), .p0_ack_o(p0_ack), .p0_data_o(p0_rdata),
        .p1_enable_i(p1_enable), .p1_write_i(p1_write), .p1_addr_i(p1_addr),
        .p1_data_i(p1_data), .p1_ack_o(p1_ack), .p1_data_o(p1_rdata),
        .mem_enable_o(mem_enable), .mem_write_o(mem_write), .mem_addr_o(mem_addr),
        .mem_data_o(mem_data), .mem_ack_i(mem_ack), .mem_data_i(mem_rdata),
        .grant_o(grant), .timeout_o(timeout)
    );

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .LINE_W(LINE_W), .FIXED_PRIO(1), .TIMEOUT_CYCLES(0)
    ) dut_fp (
        .clk_i(clk), .rst_i(rst_i),
        .p0_enable_i(fp_p0_enable), .p0_write_i(1'b0), .p0_addr_i(32'h0000_0100),
        .p0_data_i('0), .p0_ack_o(fp_p0_ack), .p0_data_o(fp_p0_rdata),
        .p1_enable_i(fp_p1_enable), .p1_write_i(1'b0), .p1_addr_i(32'h0000_0200),
        .p1_data_i('0), .p1_ack_o(fp_p1_ack), .p1_data_o(fp_p1_rdata),
        .mem_enable_o(fp_mem_enable), .mem_write_o(fp_mem_write), .mem_addr_o(fp_mem_addr),
        .mem_data_o(fp_mem_data), .mem_ack_i(fp_mem_ack), .mem_data_i({32{8'h3C}}),
        .grant_o(fp_grant), .timeout_o(fp_timeout)
    );

    // Memory model for the fixed-priority instance: acks on the third
    // falling edge of every request.
    always @(negedge clk) begin
        if (rst_i) begin
            fp_cnt     = 0;
            fp_mem_ack = 1'b0;
        end else begin
            fp_mem_ack = 1'b0;
            if (fp_mem_enable) begin
                fp_cnt = fp_cnt + 1;
                if (fp_cnt == 3) begin
                    fp_mem_ack = 1'b1;
                    fp_cnt     = 0;
                end
            end
        end
    end

    // Remembers whether the starved port ever got an ack.
    always @(negedge clk) begin
        if (fp_p0_ack === 1'b1) fp_p0_seen = 1'b1;
    end

    // Hard stop in case something above loops forever.
    initial begin
        #1_000_000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] global timeout");
    end

    task automatic checkOutput(input string tag, input logic [LINE_W-1:0] actual,
                               input logic [LINE_W-1:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, want %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int port, input logic en, input logic wr,
                                 input logic [ADDR_W-1:0] addr, input logic [LINE_W-1:0] data);
        if (port == 0) begin
            p0_enable = en; p0_write = wr; p0_addr = addr; p0_data = data;
        end else begin
            p1_enable = en; p1_write = wr; p1_addr = addr; p1_data = data;
        end
    endtask

    task automatic doReset();
        rst_i = 1'b1;
        mem_ack = 1'b0; mem_rdata = '0;
        fp_p0_enable = 1'b0; fp_p1_enable = 1'b0;
        applyStimulus(0, 1'b0, 1'b0, '0, '0);
        applyStimulus(1, 1'b0, 1'b0, '0, '0);
        repeat (2) @(negedge clk);
        rst_i = 1'b0;
    endtask

    task automatic waitMemEnable(input string tag);
        int n = 0;
        while (mem_enable !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (mem_enable !== 1'b1) checkOutput({tag, "_start_timeout"}, LINE_W'(1'b0), LINE_W'(1'b1));
    endtask

    task automatic waitFpEnable(input logic level, input string tag);
        int n = 0;
        while (fp_mem_enable !== level && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (fp_mem_enable !== level) checkOutput({tag, "_wait_timeout"}, LINE_W'(fp_mem_enable), LINE_W'(level));
    endtask

    // One read on the hand-driven instance: wait for the request to reach
    // memory, ack after `latency` cycles, then check ack and line routing.
    task automatic runTransaction(input string tag, input int latency,
                                  input logic [LINE_W-1:0] line, input logic [1:0] exp_grant);
        waitMemEnable(tag);
        checkOutput({tag, "_grant"}, LINE_W'(grant), LINE_W'(exp_grant));
        repeat (latency - 1) @(negedge clk);
        mem_ack = 1'b1; mem_rdata = line;
        @(negedge clk);
        mem_ack = 1'b0;
        checkOutput({tag, "_ack"}, LINE_W'({p1_ack, p0_ack}), LINE_W'(exp_grant));
        checkOutput({tag, "_data"}, exp_grant[1] ? p1_rdata : p0_rdata, line);
    endtask

    initial begin
        logic stable;
        logic [LINE_W-1:0] line_a5;
        line_a5 = {32{8'hA5}};

        // Reset state
        doReset();
        checkOutput("rst_grant", LINE_W'(grant), '0);
        checkOutput("rst_mem_enable", LINE_W'({mem_enable, mem_write}), '0);
        checkOutput("rst_mem_addr", LINE_W'(mem_addr), '0);
        checkOutput("rst_acks", LINE_W'({p0_ack, p1_ack, timeout}), '0);
        checkOutput("rst_p1_data", p1_rdata, '0);

        // 1: lone p1 read, memory acks after 10 BUSY cycles
        applyStimulus(1, 1'b1, 1'b0, 32'h0000_0200, '0);
        checkOutput("t1_enable_before", LINE_W'(mem_enable), '0);
        @(negedge clk);
        checkOutput("t1_enable_latency", LINE_W'(mem_enable), LINE_W'(1'b1));
        checkOutput("t1_grant", LINE_W'(grant), LINE_W'(2'b10));
        checkOutput("t1_addr", LINE_W'(mem_addr), LINE_W'(32'h200));
        checkOutput("t1_write", LINE_W'(mem_write), '0);
        stable = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (mem_enable !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 32'h200) stable = 1'b0;
        end
        checkOutput("t1_busy_stable", LINE_W'(stable), LINE_W'(1'b1));
        mem_ack = 1'b1; mem_rdata = line_a5;
        @(negedge clk);
        mem_ack = 1'b0;
        checkOutput("t1_p1_ack", LINE_W'(p1_ack), LINE_W'(1'b1));
        checkOutput("t1_p1_data", p1_rdata, line_a5);
        checkOutput("t1_p0_ack", LINE_W'(p0_ack), '0);
        checkOutput("t1_resp_idle", LINE_W'({mem_enable, grant}), '0);
        applyStimulus(1, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        checkOutput("t1_ack_pulse", LINE_W'(p1_ack), '0);
        checkOutput("t1_data_hold", p1_rdata, line_a5);
        checkOutput("t1_gap", LINE_W'(mem_enable), '0);
        checkOutput("t1_no_timeout", LINE_W'(timeout), '0);

        // 2: simultaneous requests after reset, round-robin alternation
        doReset();
        applyStimulus(0, 1'b1, 1'b0, 32'h0000_0100, '0);
        applyStimulus(1, 1'b1, 1'b0, 32'h0000_0200, '0);
        runTransaction("t2_g0", 3, {32{8'h11}}, 2'b01);
        checkOutput("t2_p1_data_zero", p1_rdata, '0);
        runTransaction("t2_g1", 3, {32{8'h22}}, 2'b10);
        runTransaction("t2_g2", 3, {32{8'h33}}, 2'b01);
        runTransaction("t2_g3", 3, {32{8'h44}}, 2'b10);
        checkOutput("t2_p0_data_hold", p0_rdata, {32{8'h33}});
        applyStimulus(0, 1'b0, 1'b0, '0, '0);
        applyStimulus(1, 1'b0, 1'b0, '0, '0);

        // 3: fixed priority, both requesting for 4 transactions
        fp_p0_enable = 1'b1; fp_p1_enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            waitFpEnable(1'b1, "t3_start");
            checkOutput("t3_grant", LINE_W'(fp_grant), LINE_W'(2'b10));
            waitFpEnable(1'b0, "t3_end");
            checkOutput("t3_p1_ack", LINE_W'(fp_p1_ack), LINE_W'(1'b1));
        end
        fp_p0_enable = 1'b0; fp_p1_enable = 1'b0;
        checkOutput("t3_p0_never_acked", LINE_W'(fp_p0_seen), '0);

        // 4: p1 write, inputs changed while BUSY must not leak through
        @(negedge clk);
        applyStimulus(1, 1'b1, 1'b1, 32'h0000_0040, LINE_W'(32'h1234));
        waitMemEnable("t4");
        checkOutput("t4_write", LINE_W'(mem_write), LINE_W'(1'b1));
        checkOutput("t4_addr", LINE_W'(mem_addr), LINE_W'(32'h40));
        checkOutput("t4_data", mem_data, LINE_W'(32'h1234));
        applyStimulus(1, 1'b1, 1'b0, 32'h0000_0080, LINE_W'(32'hFFFF));
        stable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (mem_write !== 1'b1 || mem_addr !== 32'h40 || mem_data !== LINE_W'(32'h1234)) stable = 1'b0;
        end
        checkOutput("t4_held", LINE_W'(stable), LINE_W'(1'b1));
        mem_ack = 1'b1; mem_rdata = LINE_W'(32'hDEAD);
        @(negedge clk);
        mem_ack = 1'b0;
        checkOutput("t4_p1_ack", LINE_W'({p1_ack, p0_ack}), LINE_W'(2'b10));
        applyStimulus(1, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        checkOutput("t4_ack_once", LINE_W'(p1_ack), '0);

        // 5: reset during BUSY, then a late memory ack
        @(negedge clk);
        applyStimulus(0, 1'b1, 1'b0, 32'h0000_0300, '0);
        waitMemEnable("t5");
        repeat (2) @(negedge clk);
        rst_i = 1'b1;
        applyStimulus(0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        rst_i = 1'b0;
        mem_ack = 1'b1; mem_rdata = LINE_W'(32'h77);
        checkOutput("t5_mem_ctrl", LINE_W'({mem_enable, mem_write, grant}), '0);
        checkOutput("t5_mem_addr", LINE_W'(mem_addr), '0);
        checkOutput("t5_p1_data", p1_rdata, '0);
        @(negedge clk);
        mem_ack = 1'b0;
        checkOutput("t5_no_ack", LINE_W'({p0_ack, p1_ack, mem_enable}), '0);
        @(negedge clk);
        checkOutput("t5_no_ack_later", LINE_W'({p0_ack, p1_ack}), '0);
        applyStimulus(0, 1'b1, 1'b0, 32'h0000_0300, '0);
        runTransaction("t5_after", 2, {32{8'h5A}}, 2'b01);
        applyStimulus(0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);

        // 6: memory never acks, watchdog trips after 16 BUSY cycles
        applyStimulus(0, 1'b1, 1'b0, 32'h0000_0400, '0);
        waitMemEnable("t6");
        repeat (15) @(negedge clk);
        checkOutput("t6_not_yet", LINE_W'(timeout), '0);
        @(negedge clk);
        checkOutput("t6_tripped", LINE_W'(timeout), LINE_W'(1'b1));
        repeat (5) @(negedge clk);
        checkOutput("t6_sticky", LINE_W'(timeout), LINE_W'(1'b1));
        checkOutput("t6_still_busy", LINE_W'({mem_enable, grant}), LINE_W'(3'b101));
        rst_i = 1'b1;
        applyStimulus(0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        rst_i = 1'b0;
        checkOutput("t6_cleared", LINE_W'({timeout, grant}), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Two-requester arbiter that shares the single 256-bit off-chip data-memory port between the instruction-side cache (port 0) and the data cache (port 1).
Sits between both caches and the memory model, replacing the direct dcache-to-memory connection at CPU top level.
Serialises line fills and write-backs, holds memory-side signals stable for the whole transaction, and routes the ack and read line back to the granted requester.

Parameters:
ADDR_W, 32, memory address width
LINE_W, 256, cache-line data width
FIXED_PRIO, 0, 0 = round-robin on contention; 1 = port 1 always wins
TIMEOUT_CYCLES, 0, BUSY cycles before timeout_o sets; 0 disables the watchdog

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
p0_enable_i  in  1  port 0 request; held until p0_ack_o seen
p0_write_i  in  1  port 0 write (1) / read (0)
p0_addr_i  in  ADDR_W  port 0 line address
p0_data_i  in  LINE_W  port 0 write line
p0_ack_o  out  1  port 0 completion pulse
p0_data_o  out  LINE_W  port 0 read line, valid with p0_ack_o
p1_enable_i, p1_write_i, p1_addr_i, p1_data_i, p1_ack_o, p1_data_o  same as port 0, for port 1
mem_enable_o  out  1  memory request
mem_write_o  out  1  memory write
mem_addr_o  out  ADDR_W  memory address
mem_data_o  out  LINE_W  memory write line
mem_ack_i  in  1  memory completion pulse
mem_data_i  in  LINE_W  memory read line
grant_o  out  2  one-hot current owner; 00 when idle
timeout_o  out  1  sticky watchdog flag

Behaviour:
- Clock and reset: one clock clk_i; rst_i is synchronous, active-high.
- Reset: state IDLE. All outputs 0. last_grant = 1, so the first tie goes to port 0. Timeout counter 0.
- All outputs are registered.
- FSM states:
  - IDLE: sample the enables. If none is set, stay. Otherwise pick a winner, latch its write/addr/data into the mem_* registers, set grant_o, go to BUSY.
  - BUSY: mem_enable_o = 1. mem_write_o, mem_addr_o and mem_data_o are held constant; requester inputs are not re-sampled. On mem_ack_i, capture mem_data_i and go to RESP.
  - RESP: exactly one cycle. The granted port's ack_o = 1 and its data_o = captured line. mem_enable_o = 0, grant_o cleared, last_grant updated. Next state is IDLE.
- Latency:
  - Request sampled at IDLE edge t gives mem_enable_o high from t+1.
  - mem_ack_i sampled at edge u gives ack_o high in cycle u+1 (1-cycle response latency).
  - Back-to-back transactions have a minimum gap of 1 IDLE cycle.
- Arbitration:
  - Single request: granted.
  - Both requesting, FIXED_PRIO = 0: grant the port not equal to last_grant.
  - Both requesting, FIXED_PRIO = 1: port 1 wins; port 0 starvation is accepted.
- Requester contract: the requester drops enable in the cycle after ack_o. The IDLE that follows RESP therefore does not see a stale request.
- data_o of the non-granted port stays 0. data_o of the granted port holds its value until the next RESP for that port.
- mem_ack_i outside BUSY is ignored.
- Writes also complete via RESP; the ack_o pulse is generated and data_o is don't-care, driven with the captured value.
- Watchdog (TIMEOUT_CYCLES > 0):
  - The counter increments each BUSY cycle and clears on entering BUSY.
  - When the count reaches TIMEOUT_CYCLES, timeout_o is set and stays set until rst_i.
  - The transaction continues waiting; the watchdog does not change FSM state.
- Reset mid-transaction: next edge forces IDLE and all outputs 0. A late mem_ack_i is ignored and no ack_o is produced.

Decomposition:
- Package mem_arb_pkg:
  - state enum {IDLE, BUSY, RESP};
  - ADDR_W / LINE_W defaults;
  - port index constants PORT_I = 0, PORT_D = 1.
- Sub-module rr_arb2: combinational 2-way picker. Inputs: req[1:0], last_grant, fixed_prio. Output: one-hot gnt.
- FSM, datapath registers and watchdog live in the top module.

Test Plan:
1. p1 read 0x0000_0200 alone; memory acks 10 cycles after enable with line 0xA5..A5 -> mem_enable_o rises 1 cycle after request; addr 0x200 and write 0 stable through BUSY; p1_ack_o pulses 1 cycle after mem_ack_i with p1_data_o = 0xA5..A5; p0_ack_o stays 0.
2. After reset, p0 and p1 request in the same cycle (FIXED_PRIO = 0) -> p0 granted first (grant_o = 01), p1 granted next (grant_o = 10); with both re-requesting continuously, grants alternate 0, 1, 0, 1.
3. FIXED_PRIO = 1, both requesting continuously for 4 transactions -> grant_o = 10 every time; p0_ack_o never asserts.
4. p1 write addr 0x40, data 0x1234 in the low word, then p1 changes addr/data mid-BUSY -> mem_write_o = 1, mem_addr_o = 0x40, mem_data_o unchanged until RESP; p1_ack_o pulses once.
5. rst_i asserted for 1 cycle during BUSY, then mem_ack_i arrives -> all outputs 0 the cycle after reset; no ack_o pulse; next request is served normally.
6. TIMEOUT_CYCLES = 16, memory never acks -> timeout_o rises after the 16th BUSY cycle and stays 1; grant_o remains set; cleared only by rst_i.
